// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, state encoding and field widths for the core sequencer
package core_pkg;

    localparam int OP_W  = 7;
    localparam int REG_W = 5;

    localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        FETCH     = ST_FETCH,
        DECODE    = ST_DECODE,
        EXECUTE   = ST_EXECUTE,
        MEMORY    = ST_MEMORY,
        WRITEBACK = ST_WRITEBACK,
        HALT      = ST_HALT
    } state_e;

    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic op_is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable up-counter with clear and terminal flag for memory waits
module seq_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int W           = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         terminal
);

    localparam logic [W-1:0] TERM_VAL = MEM_TIMEOUT[W-1:0];
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign terminal = (count_q == TERM_VAL);

    // Clear has priority over load; counting saturates at the terminal value
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (inc && !terminal) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/memory/write-back sequencer
module core_sequencer
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              halt_req,
    input  logic              instr_valid,
    input  logic [6:0]        operation,
    input  logic              write,
    input  logic [4:0]        rw,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              ir_en,
    output logic              alu_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic              reg_write,
    output logic              busy,
    output logic [2:0]        state,
    output logic              illegal_op,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               tmr_clr, tmr_load, tmr_inc, tmr_term;
    state_e             retire_state;

    seq_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .W           (8)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (8'd1),
        .inc      (tmr_inc),
        .terminal (tmr_term)
    );

    assign state       = state_q;
    assign busy        = (state_q != IDLE) && (state_q != HALT);
    assign illegal_op  = illegal_q;
    assign timeout_err = timeout_q;
    assign instr_count = count_q;

    // Where an instruction goes once it has retired (or been skipped)
    always_comb begin
        retire_state = IDLE;
        if (halt_req) begin
            retire_state = HALT;
        end else if (run) begin
            retire_state = FETCH;
        end
    end

    // Next-state, strobe decode and timer control
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        alu_en    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        tmr_load  = 1'b0;
        tmr_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_en = instr_valid;
                if (instr_valid) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (op_supported(operation)) begin
                    state_d = EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    pc_en     = 1'b1;
                    state_d   = retire_state;
                end
            end
            EXECUTE: begin
                alu_en = 1'b1;
                if (op_is_mem(operation)) begin
                    tmr_load = 1'b1;
                    state_d  = MEMORY;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                mem_req = 1'b1;
                mem_we  = (operation == OP_STORE);
                tmr_inc = 1'b1;
                // An ack on the terminal cycle still completes normally
                if (mem_ack) begin
                    if (operation == OP_STORE) begin
                        pc_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                        state_d = retire_state;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (tmr_term) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end
            end
            WRITEBACK: begin
                reg_write = write && (rw != '0);
                pc_en     = 1'b1;
                count_d   = count_q + CNT_ONE;
                state_d   = retire_state;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        tmr_clr = (state_q != MEMORY) && !tmr_load;
    end

    // Sequencer state, sticky error flags and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that steps the core's fetch, decode and datapath (execute/memory/write-back) stages one instruction at a time. It produces the stage enables, the register-file write strobe and the PC advance. It also handshakes with data memory for loads and stores, and reports retire count and error status.
- Sits between the fetch unit, the decoder outputs (operation, write, rw) and the datapath inside the core top level.

Parameters:
- MEM_TIMEOUT, 16: max cycles MEMORY waits for mem_ack before error; legal range 2..255.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- run  input  1  level; permits starting a new instruction.
- halt_req  input  1  level; sampled only at retire.
- instr_valid  input  1  fetch has a valid instruction word this cycle.
- operation  input  7  decoded opcode field.
- write  input  1  decoder register-write request.
- rw  input  5  destination register index.
- mem_ack  input  1  data memory completes the current request.
- pc_en  output  1  advance PC (1-cycle pulse at retire).
- ir_en  output  1  latch instruction register.
- alu_en  output  1  datapath execute enable.
- mem_req  output  1  memory request, held until ack or timeout.
- mem_we  output  1  store qualifier, valid only while mem_req=1.
- reg_write  output  1  register-file write strobe.
- busy  output  1  high in every state except IDLE and HALT.
- state  output  3  current FSM state, for debug.
- illegal_op  output  1  sticky: an unsupported opcode was decoded.
- timeout_err  output  1  sticky: memory timeout occurred.
- instr_count  output  CNT_W  retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async): state=IDLE and all outputs 0. Timer, instr_count and sticky flags also clear to 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Encoding 7 is unreachable and recovers to IDLE.
- Outputs are decoded from state plus the inputs named below. There are no extra output registers.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: ir_en = instr_valid. If instr_valid=1, go to DECODE; otherwise stay, with no timeout.
- DECODE: supported opcodes are 0110011 (R-type), 0010011 (OP-IMM), 0000011 (LOAD) and 0100011 (STORE).
  - Supported opcode: go to EXECUTE.
  - Any other opcode: set illegal_op and pulse pc_en (skip the instruction). instr_count is not incremented. Next state follows the retire rule.
- EXECUTE: alu_en=1 for exactly 1 cycle. LOAD/STORE go to MEMORY; all others go to WRITEBACK.
- MEMORY: mem_req=1 and mem_we=(opcode==STORE). The timer counts cycles spent in MEMORY, starting at 1.
  - mem_ack=1, LOAD: go to WRITEBACK.
  - mem_ack=1, STORE: retire in this cycle (pc_en=1, instr_count+1), then apply the retire rule.
  - Timer reaches MEM_TIMEOUT with no ack: set timeout_err, drop mem_req, go to HALT.
  - An ack arriving in the same cycle as the timer reaching MEM_TIMEOUT wins (no error).
- WRITEBACK: reg_write = write && (rw!=0); x0 is never written. pc_en=1, instr_count+1, then the retire rule.
- Retire rule: if halt_req=1, go to HALT. Otherwise go to FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction never aborts; the current instruction completes.
- HALT: all strobes 0, busy=0. Leave only via reset.
- operation, write and rw must be held stable by the decoder from DECODE through WRITEBACK. The sequencer does not re-latch them.
- At most one of ir_en, alu_en, reg_write is high in any cycle. pc_en is high in at most one cycle per instruction.
- Reset asserted mid-MEMORY: mem_req drops combinationally with the state change. No retire and no count.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE;
  - the state encoding localparams;
  - the operation width (7) and register index width (5).
- One sub-module, seq_timer: a loadable up-counter with a clear input and a terminal flag (parameter MEM_TIMEOUT), instantiated for the MEMORY wait.

Test Plan:
- R-type flow: reset, run=1, instr_valid=1, operation=0110011, write=1, rw=5.
  - Expect FETCH→DECODE→EXECUTE→WRITEBACK.
  - reg_write=1 and pc_en=1 in cycle 4 after FETCH entry; instr_count=1.
- Load with 3-cycle ack: operation=0000011, mem_ack asserted in the 3rd MEMORY cycle.
  - Expect mem_req high 3 cycles, mem_we=0, then WRITEBACK with reg_write=1; instr_count=1.
- Store timeout: operation=0100011, mem_ack never asserted, MEM_TIMEOUT=16.
  - Expect mem_req and mem_we high exactly 16 cycles, then timeout_err=1 and state=HALT=6.
  - No pc_en; stays in HALT until reset.
- Illegal and x0: operation=1111111 gives illegal_op=1, pc_en pulse and instr_count unchanged.
  - Next, R-type with rw=0 and write=1: reg_write stays 0 and instr_count increments.
- Halt and run control: halt_req=1 during EXECUTE leads to HALT after retire.
  - Separately, run dropped during MEMORY: the instruction completes, then IDLE with busy=0.
- Async reset and wrap: reset mid-MEMORY clears all outputs in the same cycle without waiting for a clock edge.
  - With CNT_W=4, 16 retires wrap instr_count to 0.
